// File: rtl/cc3000_apb_spi_host.sv
// APB3 slave bridging Cortex-M3 software to the CC3000 SPI port: TX/RX FIFOs plus a mode-1 shift engine.
// Optional macro CC3000_SPI_INTR_EN enables the INTEN register and the registered FABINT output.
module cc3000_apb_spi_host #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 8,
  parameter int CLKDIV_RST = 4
) (
  input  logic              SYSCLK,
  input  logic              NSYSRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              SPI_SCLK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
  output logic              SPI_CS_N,
  input  logic              SPI_IRQ_N,
  output logic              FABINT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, LOAD, LEAD, TRAIL, DONE} st_t;
  st_t state, state_n;

  logic              en, cs, rxovf, irqfall;
  logic [7:0]        clkdiv, div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shifter;
  logic              sclk_q, mosi_q;
  logic [2:0]        irq_sync;
  logic              irq_fall;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]       tx_wp, tx_rp, rx_wp, rx_rp;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop, rx_done, busy, half_done;
  logic [DATA_W-1:0] tx_head;

  // APB decode; the two address LSBs never take part in the match
  logic              acc, wr, rd, mapped;
  logic              sel_ctrl, sel_stat, sel_tx, sel_rx, sel_inten;
  logic [ADDR_W-1:0] a;
  logic [31:0]       status;
  logic              unused_bits;

  assign unused_bits = ^{PWDATA[31:16], PADDR[1:0]};
  assign acc       = PSEL & PENABLE;
  assign wr        = acc & PWRITE;
  assign rd        = acc & ~PWRITE;
  assign a         = {PADDR[ADDR_W-1:2], 2'b00};
  assign sel_ctrl  = (a == ADDR_W'(8'h00));
  assign sel_stat  = (a == ADDR_W'(8'h04));
  assign sel_tx    = (a == ADDR_W'(8'h08));
  assign sel_rx    = (a == ADDR_W'(8'h0C));
  assign sel_inten = (a == ADDR_W'(8'h10));
  assign mapped    = sel_ctrl | sel_stat | sel_tx | sel_rx | sel_inten;

  assign PREADY  = 1'b1;
  assign PSLVERR = acc & (~mapped | (PWRITE & sel_tx & tx_full) | (~PWRITE & sel_rx & rx_empty));

  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign tx_empty = (tx_wp == tx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign tx_head  = tx_mem[tx_rp[AW-1:0]];

  assign tx_push  = wr & sel_tx & ~tx_full;
  assign rx_pop   = rd & sel_rx & ~rx_empty;
  assign rx_push  = rx_done & ~rx_full;
  assign irq_fall = irq_sync[2] & ~irq_sync[1];

  assign status = {24'b0, irqfall, rxovf, irq_sync[1], busy, rx_empty, rx_full, tx_empty, tx_full};

`ifdef CC3000_SPI_INTR_EN
  logic [2:0] inten;
  logic       fabint_q;
  always_ff @(posedge SYSCLK) begin
    if (!NSYSRESET) begin
      inten    <= '0;
      fabint_q <= 1'b0;
    end else begin
      if (wr & sel_inten) inten <= PWDATA[2:0];
      fabint_q <= |(inten & {irqfall, ~rx_empty, tx_empty});
    end
  end
  assign FABINT = fabint_q;
`else
  assign FABINT = 1'b0;
`endif

  always_comb begin
    PRDATA = '0;
    if (rd) begin
      if (sel_ctrl)      PRDATA = {16'b0, clkdiv, 6'b0, cs, en};
      else if (sel_stat) PRDATA = status;
      else if (sel_rx && !rx_empty) PRDATA = 32'(rx_mem[rx_rp[AW-1:0]]);
`ifdef CC3000_SPI_INTR_EN
      else if (sel_inten) PRDATA = {29'b0, inten};
`endif
    end
  end

  // Control and sticky status; a fresh event wins over a same-cycle W1C
  always_ff @(posedge SYSCLK) begin
    if (!NSYSRESET) begin
      en       <= 1'b0;
      cs       <= 1'b0;
      clkdiv   <= 8'(CLKDIV_RST);
      rxovf    <= 1'b0;
      irqfall  <= 1'b0;
      irq_sync <= '1;
    end else begin
      irq_sync <= {irq_sync[1:0], SPI_IRQ_N};
      if (wr & sel_ctrl) begin
        en     <= PWDATA[0];
        cs     <= PWDATA[1];
        clkdiv <= PWDATA[15:8];
      end
      if (rx_done & rx_full)            rxovf <= 1'b1;
      else if (wr & sel_stat & PWDATA[6]) rxovf <= 1'b0;
      if (irq_fall)                      irqfall <= 1'b1;
      else if (wr & sel_stat & PWDATA[7]) irqfall <= 1'b0;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!NSYSRESET) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= PWDATA[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= shifter;
  end

  // Engine FSM
  always_ff @(posedge SYSCLK) begin
    if (!NSYSRESET) state <= IDLE;
    else            state <= state_n;
  end

  assign half_done = (div_cnt == clkdiv);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (en && !tx_empty) state_n = LOAD;
      LOAD:  state_n = LEAD;
      LEAD:  if (half_done) state_n = TRAIL;
      TRAIL: if (half_done) state_n = (bit_cnt == BW'(DATA_W-1)) ? DONE : LEAD;
      DONE:  state_n = (en && !tx_empty) ? LOAD : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx_pop  = (state == LOAD);
    rx_done = (state == DONE);
    busy    = (state != IDLE);
  end

  // Shift datapath: MOSI changes with the rising SCLK, MISO captured at the falling one
  always_ff @(posedge SYSCLK) begin
    if (!NSYSRESET) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shifter <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      div_cnt <= ((state == LEAD || state == TRAIL) && state_n == state) ? div_cnt + 1'b1 : '0;
      sclk_q  <= (state_n == LEAD);
      case (state)
        LOAD: begin
          shifter <= tx_head;
          bit_cnt <= '0;
          mosi_q  <= tx_head[DATA_W-1];
        end
        LEAD: if (state_n == TRAIL) shifter <= {shifter[DATA_W-2:0], SPI_MISO};
        TRAIL: if (state_n == LEAD) begin
          bit_cnt <= bit_cnt + 1'b1;
          mosi_q  <= shifter[DATA_W-1];
        end
        default: ;
      endcase
    end
  end

  assign SPI_SCLK = sclk_q;
  assign SPI_MOSI = mosi_q;
  assign SPI_CS_N = ~cs;
endmodule

// File: tb/tb_cc3000_apb_spi_host.sv
// Directed bench for cc3000_apb_spi_host with MOSI looped back to MISO.
module tb_cc3000_apb_spi_host;
  localparam logic [7:0] A_CTRL = 8'h00, A_STAT = 8'h04, A_TX = 8'h08, A_RX = 8'h0C, A_INTEN = 8'h10;

  logic        clk = 1'b0;
  logic        nrst;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        sclk, mosi, miso, cs_n, irq_n, fabint;

  int  n_chk = 0;
  int  n_err = 0;
  int  rises = 0;
  time t_prev = 0, t_last = 0;

  always #5 clk = ~clk;
  assign miso = mosi;

  always @(posedge sclk) begin
    rises++;
    t_prev = t_last;
    t_last = $time;
  end

  cc3000_apb_spi_host dut (
    .SYSCLK(clk), .NSYSRESET(nrst),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .SPI_SCLK(sclk), .SPI_MOSI(mosi), .SPI_MISO(miso), .SPI_CS_N(cs_n),
    .SPI_IRQ_N(irq_n), .FABINT(fabint)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic apb_wr(input logic [7:0] ad, input logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = ad; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] ad, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = ad;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Poll STATUS until TX is drained and the engine is idle
  task automatic wait_idle(input string tag);
    logic [31:0] s;
    logic        e;
    int          n = 0;
    do begin
      apb_rd(A_STAT, s, e);
      n++;
    end while (!(s[1] && !s[4]) && n < 400);
    chk(tag, {30'b0, s[4], s[1]}, 32'h1);
  endtask

  logic [31:0] d;
  logic        e;
  int          bad;
  int          n;

  initial begin
    nrst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; irq_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    chk("rst_cs_n", {31'b0, cs_n}, 32'h1);
    chk("rst_sclk", {31'b0, sclk}, 32'h0);
    chk("rst_fabint", {31'b0, fabint}, 32'h0);
    chk("rst_prdata_idle", prdata, 32'h0);
    apb_rd(A_STAT, d, e);
    chk("rst_status", d, 32'h0000_002A);
    apb_rd(A_CTRL, d, e);
    chk("rst_ctrl", d, 32'h0000_0400);

    // Loopback at CLKDIV=0, two words
    apb_wr(A_CTRL, 32'h0000_0003, e);
    @(negedge clk);
    chk("cs_asserted", {31'b0, cs_n}, 32'h0);
    rises = 0;
    apb_wr(A_TX, 32'hA5, e);
    apb_wr(A_TX, 32'h3C, e);
    wait_idle("lb_idle");
    chk("lb_rises", rises, 16);
    apb_rd(A_RX, d, e);
    chk("lb_rx0", d, 32'hA5);
    apb_rd(A_RX, d, e);
    chk("lb_rx1", d, 32'h3C);
    apb_rd(A_STAT, d, e);
    chk("lb_rxempty", {31'b0, d[3]}, 32'h1);

    // CLKDIV=1: 2-cycle half period, SCLK period 40 ns
    apb_wr(A_CTRL, 32'h0000_0103, e);
    rises = 0;
    apb_wr(A_TX, 32'h5A, e);
    wait_idle("div1_idle");
    chk("div1_rises", rises, 8);
    chk("div1_period", 32'(t_last - t_prev), 32'd40);
    apb_rd(A_RX, d, e);
    chk("div1_rx", d, 32'h5A);

    // Fill TX while disabled, overflow push is rejected
    apb_wr(A_CTRL, 32'h0000_0002, e);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      apb_wr(A_TX, 32'(i + 1), e);
      if (e) bad++;
    end
    chk("fill_no_err", bad, 0);
    apb_wr(A_TX, 32'h99, e);
    chk("fill_9th_err", {31'b0, e}, 32'h1);
    apb_rd(A_STAT, d, e);
    chk("fill_txfull", {31'b0, d[0]}, 32'h1);
    rises = 0;
    apb_wr(A_CTRL, 32'h0000_0003, e);
    wait_idle("fill_idle");
    chk("fill_rises", rises, 64);
    apb_rd(A_STAT, d, e);
    chk("fill_rxfull_noovf", d & 32'h44, 32'h04);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      apb_rd(A_RX, d, e);
      if (e || d !== 32'(i + 1)) bad++;
    end
    chk("fill_rx_data", bad, 0);

    // Error responses
    apb_rd(A_RX, d, e);
    chk("rx_empty_data", d, 32'h0);
    chk("rx_empty_err", {31'b0, e}, 32'h1);
    apb_rd(8'h14, d, e);
    chk("unmapped_err", {31'b0, e}, 32'h1);

    // RX overflow: nine words, no reads
    for (int i = 0; i < 9; i++) apb_wr(A_TX, 32'h11 + 32'(i), e);
    wait_idle("ovf_idle");
    apb_rd(A_STAT, d, e);
    chk("ovf_flags", d & 32'h44, 32'h44);
    apb_wr(A_STAT, 32'h40, e);
    apb_rd(A_STAT, d, e);
    chk("ovf_w1c", d & 32'h44, 32'h04);
    apb_rd(A_RX, d, e);
    chk("ovf_first_word", d, 32'h11);
    for (int i = 0; i < 7; i++) apb_rd(A_RX, d, e);
    chk("ovf_last_word", d, 32'h18);

    // CC3000 IRQ falling edge
`ifdef CC3000_SPI_INTR_EN
    apb_wr(A_INTEN, 32'h4, e);
    apb_rd(A_INTEN, d, e);
    chk("inten_rb", d, 32'h4);
    @(posedge clk); #1 irq_n = 1'b0;
    n = 0;
    @(negedge clk);
    while (n < 8 && fabint !== 1'b1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("fabint_rise", {31'b0, (n >= 1 && n <= 4)}, 32'h1);
    irq_n = 1'b1;
    apb_rd(A_STAT, d, e);
    chk("irqfall_set", {31'b0, d[7]}, 32'h1);
    apb_wr(A_STAT, 32'h80, e);
    @(posedge clk);
    @(negedge clk);
    chk("fabint_clr", {31'b0, fabint}, 32'h0);
`else
    apb_wr(A_INTEN, 32'h7, e);
    chk("inten_wr_noerr", {31'b0, e}, 32'h0);
    apb_rd(A_INTEN, d, e);
    chk("inten_rd_zero", d, 32'h0);
    @(posedge clk); #1 irq_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 irq_n = 1'b1;
    @(negedge clk);
    chk("fabint_tied", {31'b0, fabint}, 32'h0);
    apb_rd(A_STAT, d, e);
    chk("irqfall_set", {31'b0, d[7]}, 32'h1);
    apb_wr(A_STAT, 32'h80, e);
`endif
    apb_rd(A_STAT, d, e);
    chk("irqfall_w1c", {31'b0, d[7]}, 32'h0);

    // Reset in the middle of a slow transfer
    apb_wr(A_CTRL, 32'h0000_0F03, e);
    apb_wr(A_TX, 32'h81, e);
    repeat (20) @(posedge clk);
    #1 nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    chk("midrst_sclk", {31'b0, sclk}, 32'h0);
    chk("midrst_cs_n", {31'b0, cs_n}, 32'h1);
    apb_rd(A_STAT, d, e);
    chk("midrst_status", d, 32'h0000_002A);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
